// File: rtl/hilo_div_pkg.sv
// Shared definitions for the HI/LO divider: ALU control codes, FSM states and sizing.
package hilo_div_pkg;

   localparam int DIV_WIDTH  = 32;
   localparam int DIV_CYCLES = DIV_WIDTH;

   // Same 5-bit encodings the ALU decoder emits on alucontrolE.
   localparam logic [4:0] ALU_DIV  = 5'b10110;
   localparam logic [4:0] ALU_DIVU = 5'b10111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } div_state_e;

endpackage

// File: rtl/hilo_div_unit_step.sv
// One combinational restoring-division step: shift {rem, quo} left, subtract divisor if it fits.
module hilo_div_unit_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] rem_i,
   input  logic [WIDTH-1:0] quo_i,
   input  logic [WIDTH-1:0] divisor_i,
   output logic [WIDTH-1:0] rem_o,
   output logic [WIDTH-1:0] quo_o
);

   logic [WIDTH:0]   shifted;
   logic [WIDTH-1:0] trial;
   logic             ge;

   assign shifted = {rem_i, quo_i[WIDTH-1]};
   assign ge      = (shifted >= {1'b0, divisor_i});
   // When ge holds the true difference is below the divisor, so the low WIDTH bits are exact.
   assign trial   = shifted[WIDTH-1:0] - divisor_i;
   assign rem_o   = ge ? trial : shifted[WIDTH-1:0];
   assign quo_o   = {quo_i[WIDTH-2:0], ge};

endmodule

// File: rtl/hilo_div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU; stalls the pipeline until the {hi, lo} result cycle.
import hilo_div_pkg::*;

module hilo_div_unit #(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             startE,
   input  logic             signedE,
   input  logic             flushE,
   input  logic [WIDTH-1:0] srcaE,
   input  logic [WIDTH-1:0] srcbE,
   output logic [WIDTH-1:0] hiE,
   output logic [WIDTH-1:0] loE,
   output logic             divreadyE,
   output logic             divstallE
);

   localparam int               CNT_W     = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

   div_state_e       state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [WIDTH-1:0] rem_q, quo_q, dvsr_q;
   logic [WIDTH-1:0] hi_q, lo_q;
   logic             neg_quo_q, neg_rem_q, ready_q;

   logic [WIDTH-1:0] rem_d, quo_d;
   logic [WIDTH-1:0] mag_a, mag_b;
   logic             sign_a, sign_b, div_zero;

   assign sign_a   = signedE & srcaE[WIDTH-1];
   assign sign_b   = signedE & srcbE[WIDTH-1];
   assign mag_a    = sign_a ? -srcaE : srcaE;
   assign mag_b    = sign_b ? -srcbE : srcbE;
   assign div_zero = (srcbE == '0);

   hilo_div_unit_step #(.WIDTH(WIDTH)) u_step (
      .rem_i     (rem_q),
      .quo_i     (quo_q),
      .divisor_i (dvsr_q),
      .rem_o     (rem_d),
      .quo_o     (quo_d)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         rem_q     <= '0;
         quo_q     <= '0;
         dvsr_q    <= '0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
         ready_q   <= 1'b0;
      end else begin
         ready_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (startE && !flushE) begin
                  // Divide-by-zero keeps the raw dividend so the remainder comes back as presented.
                  rem_q     <= '0;
                  quo_q     <= div_zero ? srcaE : mag_a;
                  dvsr_q    <= mag_b;
                  neg_quo_q <= !div_zero && (sign_a ^ sign_b);
                  neg_rem_q <= !div_zero && sign_a;
                  cnt_q     <= '0;
                  state_q   <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               if (flushE) begin
                  state_q <= ST_IDLE;
               end else begin
                  rem_q <= rem_d;
                  quo_q <= quo_d;
                  cnt_q <= cnt_q + 1'b1;
                  if (cnt_q == LAST_STEP) begin
                     lo_q    <= neg_quo_q ? -quo_d : quo_d;
                     hi_q    <= neg_rem_q ? -rem_d : rem_d;
                     ready_q <= 1'b1;
                     state_q <= ST_DONE;
                  end
               end
            end
            // The stalled instruction is still in E here, so startE must not relaunch it.
            ST_DONE: state_q <= ST_IDLE;
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign divstallE = ((state_q == ST_IDLE) && startE && !flushE) ||
                      ((state_q == ST_BUSY) && !flushE);
   assign hiE       = hi_q;
   assign loE       = lo_q;
   assign divreadyE = ready_q;

endmodule

// File: tb/tb_hilo_div_unit.sv
// Self-checking bench for hilo_div_unit: directed corners, random ops, flush, held start and mid-op reset.
module tb_hilo_div_unit;

   logic        clk = 1'b0;
   logic        rst, startE, signedE, flushE;
   logic [31:0] srcaE, srcbE, hiE, loE;
   logic        divreadyE, divstallE;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   hilo_div_unit #(.WIDTH(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .startE    (startE),
      .signedE   (signedE),
      .flushE    (flushE),
      .srcaE     (srcaE),
      .srcbE     (srcbE),
      .hiE       (hiE),
      .loE       (loE),
      .divreadyE (divreadyE),
      .divstallE (divstallE)
   );

   // Reference: MIPS-style division from plain 64-bit arithmetic.
   function automatic void ref_div(input logic [31:0] a, input logic [31:0] b, input bit sgn,
                                   output logic [31:0] lo, output logic [31:0] hi);
      longint sa, sb, q, r;
      if (b == 32'd0) begin
         lo = 32'hFFFF_FFFF;
         hi = a;
      end else begin
         sa = sgn ? longint'($signed(a)) : longint'({32'd0, a});
         sb = sgn ? longint'($signed(b)) : longint'({32'd0, b});
         q  = sa / sb;
         r  = sa % sb;
         lo = q[31:0];
         hi = r[31:0];
      end
   endfunction

   // Launch one op after a posedge, hold startE through the result cycle, then drop it.
   task automatic do_op(input logic [31:0] a, input logic [31:0] b, input bit sgn,
                        output logic [31:0] lo, output logic [31:0] hi,
                        output int lat, output int stalls);
      @(posedge clk); #1;
      startE = 1'b1; signedE = sgn; srcaE = a; srcbE = b;
      lat = -1; stalls = 0; lo = 'x; hi = 'x;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (divstallE) stalls++;
         if (divreadyE) begin
            lat = k; lo = loE; hi = hiE;
            break;
         end
      end
      @(posedge clk); #1;
      startE = 1'b0;
   endtask

   task automatic check_op(input string name, input logic [31:0] a, input logic [31:0] b,
                           input bit sgn);
      logic [31:0] lo, hi, elo, ehi;
      int lat, stalls;
      ref_div(a, b, sgn, elo, ehi);
      do_op(a, b, sgn, lo, hi, lat, stalls);
      vectors++;
      if (lat !== 33) begin
         miscompares++;
         $display("FAIL %s latency: got %0d want 33", name, lat);
      end
      vectors++;
      if (stalls !== 33) begin
         miscompares++;
         $display("FAIL %s stall_cycles: got %0d want 33", name, stalls);
      end
      vectors++;
      if (lo !== elo || hi !== ehi) begin
         miscompares++;
         $display("FAIL %s result a=%h b=%h s=%0d: got lo=%h hi=%h want lo=%h hi=%h",
                  name, a, b, sgn, lo, hi, elo, ehi);
      end
      $display("op %s a=%h b=%h s=%0d lo=%h hi=%h lat=%0d", name, a, b, sgn, lo, hi, lat);
   endtask

   task automatic test_reset();
      rst = 1'b1; startE = 1'b0; signedE = 1'b0; flushE = 1'b0; srcaE = '0; srcbE = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      vectors++;
      if (loE !== 32'd0 || hiE !== 32'd0 || divreadyE !== 1'b0 || divstallE !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_state: got lo=%h hi=%h rdy=%b stall=%b want all 0",
                  loE, hiE, divreadyE, divstallE);
      end
      $display("reset lo=%h hi=%h rdy=%b stall=%b", loE, hiE, divreadyE, divstallE);
   endtask

   task automatic test_directed();
      check_op("divu_100_7",   32'd100,       32'd7,         1'b0);
      check_op("div_m7_2",     32'hFFFF_FFF9, 32'd2,         1'b1);
      check_op("div_7_m2",     32'd7,         32'hFFFF_FFFE, 1'b1);
      check_op("div_ovf",      32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
      check_op("divu_max_1",   32'hFFFF_FFFF, 32'd1,         1'b0);
      check_op("divu_5_0",     32'd5,         32'd0,         1'b0);
      check_op("div_m5_0",     32'hFFFF_FFFB, 32'd0,         1'b1);
      check_op("divu_small_big", 32'd3,       32'hFFFF_FFF0, 1'b0);
   endtask

   task automatic test_random();
      logic [31:0] a, b;
      bit sgn;
      for (int i = 0; i < 20; i++) begin
         a = $urandom;
         case ($urandom_range(0, 3))
            0: b = $urandom;
            1: b = 32'($urandom_range(1, 255));
            2: b = -32'($urandom_range(1, 255));
            default: b = ($urandom_range(0, 1) == 0) ? 32'd0 : (a >> $urandom_range(0, 31));
         endcase
         sgn = 1'($urandom_range(0, 1));
         check_op("random", a, b, sgn);
      end
   endtask

   task automatic test_flush();
      logic [31:0] lo, hi;
      int lat, stalls, early;
      early = 0;
      @(posedge clk); #1;
      startE = 1'b1; signedE = 1'b0; srcaE = 32'd100; srcbE = 32'd7;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (divreadyE) early++;
         @(posedge clk); #1;
      end
      flushE = 1'b1;
      @(negedge clk);
      vectors++;
      if (divstallE !== 1'b0) begin
         miscompares++;
         $display("FAIL flush_stall_c10: got %b want 0", divstallE);
      end
      @(posedge clk); #1;
      flushE = 1'b0; startE = 1'b0;
      @(negedge clk);
      vectors++;
      if (divstallE !== 1'b0 || divreadyE !== 1'b0 || early !== 0) begin
         miscompares++;
         $display("FAIL flush_idle_c11: got stall=%b rdy=%b early=%0d want 0 0 0",
                  divstallE, divreadyE, early);
      end
      do_op(32'd50, 32'd5, 1'b0, lo, hi, lat, stalls);
      vectors++;
      if (lat !== 33 || lo !== 32'd10 || hi !== 32'd0) begin
         miscompares++;
         $display("FAIL flush_restart: got lat=%0d lo=%h hi=%h want 33 0000000a 00000000",
                  lat, lo, hi);
      end
      $display("flush restart lo=%h hi=%h lat=%0d", lo, hi, lat);
   endtask

   task automatic test_hold_start();
      logic [31:0] lo, hi;
      int lat, stalls, pulses, stall_seen;
      do_op(32'd9, 32'd2, 1'b0, lo, hi, lat, stalls);
      pulses = 0; stall_seen = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (divreadyE) pulses++;
         if (divstallE) stall_seen++;
      end
      vectors++;
      if (lat !== 33 || lo !== 32'd4 || hi !== 32'd1 || pulses !== 0 || stall_seen !== 0) begin
         miscompares++;
         $display("FAIL hold_start: got lat=%0d lo=%h hi=%h extra=%0d stall=%0d want 33 4 1 0 0",
                  lat, lo, hi, pulses, stall_seen);
      end
      $display("hold start lo=%h hi=%h extra_pulses=%0d", lo, hi, pulses);
   endtask

   task automatic test_reset_mid();
      int pulses;
      pulses = 0;
      @(posedge clk); #1;
      startE = 1'b1; signedE = 1'b1; srcaE = 32'd1000; srcbE = 32'd3;
      repeat (5) @(posedge clk);
      #1 rst = 1'b1; startE = 1'b0;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      vectors++;
      if (loE !== 32'd0 || hiE !== 32'd0 || divreadyE !== 1'b0 || divstallE !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_mid: got lo=%h hi=%h rdy=%b stall=%b want all 0",
                  loE, hiE, divreadyE, divstallE);
      end
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (divreadyE) pulses++;
      end
      vectors++;
      if (pulses !== 0) begin
         miscompares++;
         $display("FAIL reset_mid_pulse: got %0d pulses want 0", pulses);
      end
      $display("reset mid-op lo=%h hi=%h pulses=%0d", loE, hiE, pulses);
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_flush();
      test_hold_start();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
